// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, FSM encoding
// and the default address window base.
package mmio_pkg;

  localparam logic [7:0] DEF_BASE_ADDR = 8'hF0;

  localparam logic [2:0] OFS_SWITCH    = 3'd0;
  localparam logic [2:0] OFS_BTN_LEVEL = 3'd1;
  localparam logic [2:0] OFS_BTN_EVENT = 3'd2;
  localparam logic [2:0] OFS_LEDS      = 3'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/debounce_bit.sv
// One button pin: 2-flop synchronizer followed by a stability counter that
// flips the debounced level only after DEBOUNCE_CYCLES consecutive samples
// disagree with it. rise pulses in the cycle the level is about to go 0->1.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic       meta_q, sync_q;
  logic       level_q, level_d;
  logic [7:0] cnt_q, cnt_d;

  // Count disagreeing samples; flip the level once the run is long enough.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(DEBOUNCE_CYCLES)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

  // Synchronizer and debounce state, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      meta_q  <= pin;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: answers CPU loads/stores in an 8-byte window, exposing
// synchronized switches, debounced buttons, sticky press events and LEDs.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR       = DEF_BASE_ADDR,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       rsp_ready,
  input  logic [7:0] switch,
  input  logic [4:0] buttons,
  output logic [7:0] leds
);

  state_e     state_q, state_d;
  logic       req_ready_q, req_ready_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] leds_q, leds_d;
  logic [4:0] evt_q, evt_d;
  logic [7:0] sw_meta_q, sw_sync_q;
  logic [4:0] btn_level, btn_rise;

  logic       accept, hit;
  logic [7:0] offset, rd_mux;
  logic [4:0] evt_clr;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin  (buttons[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i])
    );
  end

  // Window decode; the range check prevents wrap past 8'hFF from hitting.
  assign offset = req_addr - BASE_ADDR;
  assign hit    = (req_addr >= BASE_ADDR) && (offset < 8'd8);
  assign accept = req_valid && req_ready_q;

  // FSM next state; ready is registered so it stays low while in reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // Read mux and register side effects applied at acceptance.
  always_comb begin
    rd_mux  = '0;
    evt_clr = '0;
    rdata_d = rdata_q;
    leds_d  = leds_q;
    if (hit) begin
      case (offset[2:0])
        OFS_SWITCH:    rd_mux = sw_sync_q;
        OFS_BTN_LEVEL: rd_mux = {3'b0, btn_level};
        OFS_BTN_EVENT: rd_mux = {3'b0, evt_q};
        OFS_LEDS:      rd_mux = leds_q;
        default:       rd_mux = '0;
      endcase
    end
    if (accept) begin
      rdata_d = req_write ? 8'h00 : rd_mux;
      if (req_write && hit && offset[2:0] == OFS_LEDS)      leds_d  = req_wdata;
      if (req_write && hit && offset[2:0] == OFS_BTN_EVENT) evt_clr = req_wdata[4:0];
    end
    // A new press wins over a clear landing in the same cycle.
    evt_d = (evt_q & ~evt_clr) | btn_rise;
  end

  // State, response, LED, event and switch-synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rdata_q     <= '0;
      leds_q      <= '0;
      evt_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rdata_q     <= rdata_d;
      leds_q      <= leds_d;
      evt_q       <= evt_d;
      sw_meta_q   <= switch;
      sw_sync_q   <= sw_meta_q;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: requests push expected load data,
// a negedge monitor pops and compares on every response handshake.
module tb_mmio_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write, req_ready;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata, switch, leds;
  logic [4:0] buttons;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_ready(rsp_ready),
    .switch   (switch),
    .buttons  (buttons),
    .leds     (leds)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata %h, expected no response", rsp_rdata);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  // Present a request, wait for acceptance, optionally register the expected data.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp, input bit push);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: addr %h never accepted", addr);
    end
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for all expected responses to be consumed.
  task automatic wait_rsp();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("rsp_drained", 8'(exp_q.size()), 8'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; switch = 8'hFF; buttons = 5'h1F;

    // Reset held two cycles with pins active.
    repeat (2) @(posedge clk);
    #1;
    check("rst_leds", leds, 8'h00);
    check("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check("rst_req_ready", {7'b0, req_ready}, 8'h00);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    rst = 1'b1; buttons = 5'h00; switch = 8'h00;
    @(posedge clk);
    #1;
    check("ready_after_rst", {7'b0, req_ready}, 8'h01);
    issue(1'b0, 8'hF2, 8'h00, 8'h00, 1'b1);
    wait_rsp();

    // LED store then read-back.
    issue(1'b1, 8'hF3, 8'hA5, 8'h00, 1'b1);
    check("leds_after_store", leds, 8'hA5);
    check("store_rsp_valid", {7'b0, rsp_valid}, 8'h01);
    wait_rsp();
    issue(1'b0, 8'hF3, 8'h00, 8'hA5, 1'b1);
    wait_rsp();

    // Switch read with back-pressure on the response.
    switch = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    issue(1'b0, 8'hF0, 8'h00, 8'h3C, 1'b1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {7'b0, rsp_valid}, 8'h01);
      check("hold_rsp_rdata", rsp_rdata, 8'h3C);
      check("hold_req_ready", {7'b0, req_ready}, 8'h00);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_rsp();

    // Short glitch on button 2 must not change the level.
    buttons[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    buttons[2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    issue(1'b0, 8'hF1, 8'h00, 8'h00, 1'b1);
    wait_rsp();
    issue(1'b0, 8'hF2, 8'h00, 8'h00, 1'b1);
    wait_rsp();

    // Long press: level and sticky event both set.
    buttons[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    issue(1'b0, 8'hF1, 8'h00, 8'h04, 1'b1);
    wait_rsp();
    issue(1'b0, 8'hF2, 8'h00, 8'h04, 1'b1);
    wait_rsp();
    buttons[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    issue(1'b0, 8'hF1, 8'h00, 8'h00, 1'b1);
    wait_rsp();
    issue(1'b0, 8'hF2, 8'h00, 8'h04, 1'b1);
    wait_rsp();

    // W1C clear.
    issue(1'b1, 8'hF2, 8'h04, 8'h00, 1'b1);
    wait_rsp();
    issue(1'b0, 8'hF2, 8'h00, 8'h00, 1'b1);
    wait_rsp();

    // Rise lands on the acceptance edge of a clear: the set wins.
    // Pin high after P0 -> sync at P2 -> counter 1,2,3 at P3..P5 -> flip at P6.
    @(posedge clk);
    #1;
    buttons[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(1'b1, 8'hF2, 8'h04, 8'h00, 1'b1);
    wait_rsp();
    issue(1'b0, 8'hF2, 8'h00, 8'h04, 1'b1);
    wait_rsp();
    buttons[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Misses and reserved offsets.
    issue(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    wait_rsp();
    issue(1'b0, 8'hF5, 8'h00, 8'h00, 1'b1);
    wait_rsp();
    issue(1'b1, 8'hF7, 8'hFF, 8'h00, 1'b1);
    wait_rsp();
    check("leds_after_reserved_store", leds, 8'hA5);
    issue(1'b1, 8'h13, 8'h5A, 8'h00, 1'b1);
    wait_rsp();
    check("leds_after_miss_store", leds, 8'hA5);

    // Reset during RESP drops the pending response.
    rsp_ready = 1'b0;
    issue(1'b0, 8'hF3, 8'h00, 8'h00, 1'b0);
    check("abort_rsp_valid_before", {7'b0, rsp_valid}, 8'h01);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check("abort_req_ready", {7'b0, req_ready}, 8'h00);
    check("abort_leds", leds, 8'h00);
    rst = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    issue(1'b0, 8'hF3, 8'h00, 8'h00, 1'b1);
    wait_rsp();

    repeat (4) @(posedge clk);
    check("queue_empty_end", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-mapped I/O responder on the CPU data bus. Answers CPU load/store requests in a fixed 8-bit address window. Exposes board switches and buttons (synchronized and debounced) plus sticky button-press events, and owns the LED register. Sits between the CPU's memory port and the board pins, replacing direct pin wiring in the CPU.

Parameters:
BASE_ADDR, 8'hF0, first byte address of the window; window covers BASE_ADDR..BASE_ADDR+7.
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed before a debounced button level changes (range 1..255).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-low.
req_valid  input  1  CPU request present.
req_write  input  1  1 = store, 0 = load.
req_addr  input  8  byte address.
req_wdata  input  8  store data.
req_ready  output  1  responder can accept a request this cycle.
rsp_valid  output  1  response present.
rsp_rdata  output  8  load data; 8'h00 for stores.
rsp_ready  input  1  CPU accepts the response.
switch  input  8  raw asynchronous switch pins.
buttons  input  5  raw asynchronous button pins.
leds  output  8  LED register.

Behaviour:
- Reset: when rst==0 at a posedge, next cycle req_ready=0, rsp_valid=0, rsp_rdata=0, leds=0, sync/debounce state=0, debounced levels=0, event flags=0, FSM=IDLE. Reset mid-transaction drops the pending response and any unapplied effect.
- FSM states: IDLE, RESP.
  - IDLE: req_ready=1. req_valid&&req_ready = accept; go to RESP next cycle.
  - RESP: req_ready=0, rsp_valid=1, rsp_rdata held stable. Leave to IDLE when rsp_ready==1.
  - First response is one cycle after acceptance. Max throughput is one request per two cycles.
- Decode: offset = req_addr - BASE_ADDR, 8-bit.
  - Hit when req_addr is in BASE_ADDR..BASE_ADDR+7, with no wrap (BASE_ADDR>8'hF8 clamps the window at 8'hFF).
  - A miss is still accepted and answered: load returns 8'h00, store is ignored.
- Register map (offset):
  - 0 SWITCH, RO: 2-flop synchronized switch.
  - 1 BTN_LEVEL, RO: {3'b0, debounced buttons}.
  - 2 BTN_EVENT, W1C: {3'b0, sticky press flags}.
  - 3 LEDS, RW.
  - 4..7: reserved; read 0, writes ignored.
- Register effects happen in the acceptance cycle:
  - Store to LEDS: leds=req_wdata, visible the cycle after acceptance.
  - Load data is sampled at acceptance and held through RESP.
- Synchronizer: 2 flops per pin. Synchronized value lags the pin by 2 cycles.
- Debounce, per button, 8-bit counter:
  - Sync input == debounced level: counter=0.
  - Otherwise counter increments. On reaching DEBOUNCE_CYCLES, level flips and counter=0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Events:
  - A debounced 0->1 transition sets the event bit.
  - A store to BTN_EVENT clears bits where req_wdata is 1.
  - Set and clear on the same bit in the same cycle: set wins.
  - Loads never clear.
- Simultaneous req_valid during RESP: not accepted; the CPU must hold req_valid until req_ready.

Decomposition:
- Shared package mmio_pkg:
  - Offset constants OFS_SWITCH=0, OFS_BTN_LEVEL=1, OFS_BTN_EVENT=2, OFS_LEDS=3.
  - FSM state encoding IDLE/RESP.
  - Default BASE_ADDR.
- One sub-module, debounce_bit: 2-flop sync + counter + level. It is instantiated 5 times. Switches use the sync stage only.

Test Plan:
- Reset: hold rst=0 for 2 cycles with pins active -> leds=0, rsp_valid=0, req_ready=0, BTN_EVENT reads 0 after release; req_ready=1 the cycle after rst=1.
- LED store: store 8'hA5 to 8'hF3 -> accepted in 1 cycle, leds=8'hA5 next cycle, rsp_valid=1 with rsp_rdata=0; load 8'hF3 -> 8'hA5.
- Switch read: switch=8'h3C held 3+ cycles, load 8'hF0 -> rsp_rdata=8'h3C. Hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0.
- Debounce: buttons[2] high for 3 cycles then low -> BTN_LEVEL stays 0. Held high for 10 cycles -> BTN_LEVEL=8'h04 and BTN_EVENT=8'h04.
- Events: store 8'h04 to 8'hF2 -> BTN_EVENT=0. Debounced rise of buttons[2] in the same cycle as that store -> bit stays 1.
- Miss and abort: load 8'h10 -> 8'h00. Store 8'hFF to 8'hF7 -> leds unchanged. Assert rst=0 during RESP -> rsp_valid=0 next cycle and no response is delivered.
